multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Next-generation multicycle control unit for the 4-type ISA (R/I/J/S). It owns the state register (IF, ID, EX, MEM, WB, ST, ERR) and the return-address stack occupancy counter, and supports wait-state handshakes on instruction and data memory. It sits between the instruction register/decoder and the datapath, driving all mux selects, write strobes and ALU op every cycle.

Parameters:
FUNC_W, 5, width of inst_function field
ALUOP_W, 4, width of alu_op
STACK_DEPTH, 8, return-address stack entries (power of 2, >=2)
CNT_W, 32, perf counter width (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
inst_type  in  2  R=00, J=01, I=10, S=11 (from IR)
inst_function  in  FUNC_W  function code (from IR)
stop_bit  in  1  return-after-this-instruction flag (from IR)
zero_flag  in  1  ALU zero from the EX cycle
imem_ready  in  1  instruction fetch data valid
dmem_ready  in  1  data memory access complete
ir_load  out  1  load IR (IF and imem_ready)
ex_src, ex_sign, rs2_src, alu_src, wb_data  out  1  datapath mux selects
reg_wr, mem_rd, mem_wr  out  1  strobes
pc_wr  out  1  PC update enable
pc_src  out  2  0=stack top, 1=PC adder, 2=PC+1
pc_add_src1, pc_add_src2  out  1  PC adder operand selects
st_rd, st_wr  out  1  stack pop/push strobes
alu_op  out  ALUOP_W  ADD0 SUB1 AND2 OR3 XOR4 SLL5 SLR6
state  out  3  IF0 ID1 EX2 MEM3 WB4 ST5 ERR7
sp_count  out  $clog2(STACK_DEPTH)+1  stack occupancy
err  out  1  sticky fault (illegal op, overflow, underflow)

Behaviour:
- Reset (async): state=IF, sp_count=0, err=0; all strobes 0, pc_src=2, alu_op=ADD. Strobes are decoded from the registered state and inst fields.
- IF: hold while !imem_ready. With imem_ready: ir_load=1, then go to ID.
- ID: J(0) goes to IF with pc_wr=1, pc_src=1, add_src=0/0. JAL(1) goes to ST (push). RET(J,2) goes to ST (pop). Illegal code goes to ERR. Everything else goes to EX.
- EX: CMP (R,3) and BEQ (I,4) complete here. LW and SW go to MEM. Other legal R/I/S ops go to WB. BEQ with zero_flag: pc_src=1, add_src=1/1. Otherwise pc_src=2.
- MEM: hold while !dmem_ready, keeping mem_rd or mem_wr asserted. With dmem_ready, LW goes to WB and SW completes.
- WB: reg_wr=1 for one cycle, then complete.
- Complete: if stop_bit=1, go to ST (pop, pc_src=0). Otherwise go to IF with pc_wr=1, pc_src=2 (PC+1).
- ST push (JAL): st_wr=1, sp_count+1, pc_src=1, then IF. ST pop: st_rd=1, sp_count-1, pc_src=0, then IF. ST never chains to ST.
- Push with sp_count==STACK_DEPTH, or pop with sp_count==0: no strobe, err=1, go to ERR. ERR holds all strobes at 0 until rst.
- Legal codes: R 0-3, I 0-4, J 0-2, S 0-3. ALU map: AND/ANDI=AND; ADD/ADDI/LW/SW=ADD; SUB/CMP/BEQ=SUB; SLL/SLLV=SLL; SLR/SLRV=SLR.
- alu_src=1 for I-type and for SLL/SLR. ex_src and ex_sign are 1 for I-type and 0 for S-type.
- rst asserted mid-MEM wait: immediate return to IF with all strobes dropped.

Optional Feature:
CTRL_PERF_CNT_EN adds output ports retired_cnt[CNT_W] and stall_cnt[CNT_W].
- retired_cnt increments once per completed instruction.
- stall_cnt increments on each IF or MEM cycle with ready low.
- Both counters wrap and reset to 0.
- Without the macro, neither the ports nor the logic exist.

Decomposition:
- Package ctrl_pkg holds the state encodings, inst_type codes, function codes, ALU op codes and pc_src codes.
- One sub-module, ctrl_ret_stack_cnt, holds the occupancy counter and overflow/underflow detection.

Test Plan:
- ADD (00,1), stop=0, imem_ready=1 -> IF,ID,EX,WB,IF; reg_wr=1 in WB only; pc_src=2.
- LW (10,2), dmem_ready low 3 cycles -> MEM held 4 cycles with mem_rd=1; then WB with wb_data=1 and reg_wr=1.
- BEQ (10,4), zero_flag=1 -> EX returns to IF; pc_src=1, add_src=1/1; no reg_wr.
- 9 JALs with STACK_DEPTH=8 -> sp_count reaches 8; 9th goes to ERR with err=1 and no st_wr.
- SUB with stop=1 and sp_count=0 -> underflow, ERR, err=1. Repeat with sp_count=2 -> ST, st_rd=1, sp_count=1, pc_src=0.
- Illegal (00,5) -> ERR; rst pulse -> IF, sp_count=0, err=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, instruction
// types, function codes, ALU ops and PC source selects.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4,
        ST_ST  = 3'd5,
        ST_ERR = 3'd7
    } state_e;

    localparam logic [1:0] TYPE_R = 2'b00;
    localparam logic [1:0] TYPE_J = 2'b01;
    localparam logic [1:0] TYPE_I = 2'b10;
    localparam logic [1:0] TYPE_S = 2'b11;

    localparam int unsigned F_R_AND  = 0, F_R_ADD  = 1, F_R_SUB = 2, F_R_CMP = 3;
    localparam int unsigned F_I_ANDI = 0, F_I_ADDI = 1, F_I_LW  = 2, F_I_SW  = 3, F_I_BEQ = 4;
    localparam int unsigned F_J_J    = 0, F_J_JAL  = 1, F_J_RET = 2;
    localparam int unsigned F_S_SLL  = 0, F_S_SLR  = 1, F_S_SLLV = 2, F_S_SLRV = 3;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SLR = 4'd6
    } alu_op_e;

    localparam logic [1:0] PC_STACK = 2'd0;
    localparam logic [1:0] PC_ADDER = 2'd1;
    localparam logic [1:0] PC_INC   = 2'd2;

    // Highest legal function code per instruction type.
    function automatic int unsigned func_limit(input logic [1:0] t);
        case (t)
            TYPE_R:  return F_R_CMP;
            TYPE_I:  return F_I_BEQ;
            TYPE_J:  return F_J_RET;
            default: return F_S_SLRV;
        endcase
    endfunction

    function automatic alu_op_e alu_of(input logic [1:0] t, input int unsigned f);
        alu_op_e op;
        op = ALU_ADD;
        case (t)
            TYPE_R: case (f)
                F_R_AND:          op = ALU_AND;
                F_R_ADD:          op = ALU_ADD;
                F_R_SUB, F_R_CMP: op = ALU_SUB;
                default:          op = ALU_ADD;
            endcase
            TYPE_I: case (f)
                F_I_ANDI:                 op = ALU_AND;
                F_I_ADDI, F_I_LW, F_I_SW: op = ALU_ADD;
                F_I_BEQ:                  op = ALU_SUB;
                default:                  op = ALU_ADD;
            endcase
            TYPE_S: case (f)
                F_S_SLL, F_S_SLLV: op = ALU_SLL;
                F_S_SLR, F_S_SLRV: op = ALU_SLR;
                default:           op = ALU_ADD;
            endcase
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_ret_stack_cnt.sv
// Return-address stack occupancy counter; flags pushes into a full stack
// and pops from an empty one, which leave the count unchanged.
module ctrl_ret_stack_cnt #(
    parameter int STACK_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    output logic [$clog2(STACK_DEPTH):0] count_o,
    output logic                         ovf_o,
    output logic                         unf_o
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    logic [SP_W-1:0] count_q, count_d;

    assign ovf_o   = push_i && (count_q == SP_W'(STACK_DEPTH));
    assign unf_o   = pop_i && (count_q == '0);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (push_i && !ovf_o) begin
            count_d = count_q + SP_W'(1);
        end else if (pop_i && !unf_o) begin
            count_d = count_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for the R/I/J/S ISA with memory wait states.
// Optional CTRL_PERF_CNT_EN adds retired/stall performance counters.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int FUNC_W      = 5,
    parameter int ALUOP_W     = 4,
    parameter int STACK_DEPTH = 8
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   inst_type,
    input  logic [FUNC_W-1:0]            inst_function,
    input  logic                         stop_bit,
    input  logic                         zero_flag,
    input  logic                         imem_ready,
    input  logic                         dmem_ready,
    output logic                         ir_load,
    output logic                         ex_src,
    output logic                         ex_sign,
    output logic                         rs2_src,
    output logic                         alu_src,
    output logic                         wb_data,
    output logic                         reg_wr,
    output logic                         mem_rd,
    output logic                         mem_wr,
    output logic                         pc_wr,
    output logic [1:0]                   pc_src,
    output logic                         pc_add_src1,
    output logic                         pc_add_src2,
    output logic                         st_rd,
    output logic                         st_wr,
    output logic [ALUOP_W-1:0]           alu_op,
    output logic [2:0]                   state,
    output logic [$clog2(STACK_DEPTH):0] sp_count,
    output logic                         err
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]             retired_cnt,
    output logic [CNT_W-1:0]             stall_cnt
`endif
);
    state_e      state_q, state_d;
    logic        err_q, err_d;
    int unsigned func_u;
    logic        legal, is_i, is_s, is_j, is_jmp, is_jal, is_cmp, is_beq, is_lw, is_sw;
    logic        complete, push_req, pop_req, ovf, unf;

    assign func_u = 32'(inst_function);
    assign legal  = func_u <= func_limit(inst_type);
    assign is_i   = inst_type == TYPE_I;
    assign is_s   = inst_type == TYPE_S;
    assign is_j   = inst_type == TYPE_J;
    assign is_jmp = is_j && func_u == F_J_J;
    assign is_jal = is_j && func_u == F_J_JAL;
    assign is_cmp = inst_type == TYPE_R && func_u == F_R_CMP;
    assign is_beq = is_i && func_u == F_I_BEQ;
    assign is_lw  = is_i && func_u == F_I_LW;
    assign is_sw  = is_i && func_u == F_I_SW;

    // Last cycle of a non-jump instruction; stop_bit then diverts to a pop.
    assign complete = (state_q == ST_EX && (is_cmp || is_beq)) ||
                      (state_q == ST_MEM && dmem_ready && is_sw) ||
                      (state_q == ST_WB);

    assign push_req = (state_q == ST_ST) && is_jal;
    assign pop_req  = (state_q == ST_ST) && !is_jal;

    ctrl_ret_stack_cnt #(.STACK_DEPTH(STACK_DEPTH)) u_stack_cnt (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .pop_i   (pop_req),
        .count_o (sp_count),
        .ovf_o   (ovf),
        .unf_o   (unf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IF;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IF:  if (imem_ready) state_d = ST_ID;
            ST_ID: begin
                if (!legal)      state_d = ST_ERR;
                else if (is_jmp) state_d = ST_IF;
                else if (is_j)   state_d = ST_ST;
                else             state_d = ST_EX;
            end
            ST_EX:  if (is_lw || is_sw) state_d = ST_MEM;
                    else                state_d = ST_WB;
            ST_MEM: if (dmem_ready) state_d = ST_WB;
            ST_WB:  state_d = ST_IF;
            ST_ST:  state_d = (ovf || unf) ? ST_ERR : ST_IF;
            default: state_d = ST_ERR;
        endcase
        if (complete) begin
            state_d = stop_bit ? ST_ST : ST_IF;
        end
    end

    assign err_d = err_q || (state_d == ST_ERR);
    assign err   = err_q;
    assign state = state_q;

    always_comb begin
        ir_load     = 1'b0;
        ex_src      = 1'b0;
        ex_sign     = 1'b0;
        rs2_src     = 1'b0;
        alu_src     = 1'b0;
        wb_data     = 1'b0;
        reg_wr      = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        pc_wr       = 1'b0;
        pc_src      = PC_INC;
        pc_add_src1 = 1'b0;
        pc_add_src2 = 1'b0;
        st_rd       = 1'b0;
        st_wr       = 1'b0;
        alu_op      = ALUOP_W'(ALU_ADD);
        if (state_q inside {ST_ID, ST_EX, ST_MEM, ST_WB}) begin
            ex_src  = is_i;
            ex_sign = is_i;
            alu_src = is_i || (is_s && func_u < 2);
            rs2_src = is_sw;
        end
        case (state_q)
            ST_IF: ir_load = imem_ready;
            ST_ID: if (legal && is_jmp) begin
                pc_wr  = 1'b1;
                pc_src = PC_ADDER;
            end
            ST_EX: begin
                alu_op = ALUOP_W'(alu_of(inst_type, func_u));
                if (is_beq && zero_flag) begin
                    pc_src      = PC_ADDER;
                    pc_add_src1 = 1'b1;
                    pc_add_src2 = 1'b1;
                end
            end
            ST_MEM: begin
                alu_op = ALUOP_W'(alu_of(inst_type, func_u));
                mem_rd = is_lw;
                mem_wr = is_sw;
            end
            ST_WB: begin
                alu_op  = ALUOP_W'(alu_of(inst_type, func_u));
                reg_wr  = 1'b1;
                wb_data = is_lw;
            end
            ST_ST: begin
                if (push_req && !ovf) begin
                    st_wr  = 1'b1;
                    pc_wr  = 1'b1;
                    pc_src = PC_ADDER;
                end else if (pop_req && !unf) begin
                    st_rd  = 1'b1;
                    pc_wr  = 1'b1;
                    pc_src = PC_STACK;
                end
            end
            default: ;
        endcase
        if (complete && !stop_bit) begin
            pc_wr = 1'b1;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] retired_q, stall_q;
    logic             retire, stall;

    // An instruction retires when control returns to IF from anywhere but ERR.
    assign retire = state_q != ST_IF && state_q != ST_ERR && state_d == ST_IF;
    assign stall  = (state_q == ST_IF && !imem_ready) || (state_q == ST_MEM && !dmem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire) retired_q <= retired_q + CNT_W'(1);
            if (stall)  stall_q   <= stall_q + CNT_W'(1);
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench: a per-instruction cycle planner predicts the output trace,
// a negedge compare process checks every cycle, literals pin key points.
module tb_multicycle_ctrl_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] inst_type = 2'b00;
    logic [4:0] inst_function = 5'd0;
    logic       stop_bit = 1'b0, zero_flag = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic       ir_load, ex_src, ex_sign, rs2_src, alu_src, wb_data, reg_wr, mem_rd, mem_wr;
    logic       pc_wr, pc_add_src1, pc_add_src2, st_rd, st_wr, err;
    logic [1:0] pc_src;
    logic [3:0] alu_op, sp_count;
    logic [2:0] state;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.FUNC_W(5), .ALUOP_W(4), .STACK_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .inst_type(inst_type), .inst_function(inst_function),
        .stop_bit(stop_bit), .zero_flag(zero_flag), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .ir_load(ir_load), .ex_src(ex_src), .ex_sign(ex_sign),
        .rs2_src(rs2_src), .alu_src(alu_src), .wb_data(wb_data), .reg_wr(reg_wr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .pc_wr(pc_wr), .pc_src(pc_src),
        .pc_add_src1(pc_add_src1), .pc_add_src2(pc_add_src2), .st_rd(st_rd),
        .st_wr(st_wr), .alu_op(alu_op), .state(state), .sp_count(sp_count), .err(err)
    );

    typedef struct {
        logic [2:0] st;
        logic       imem, dmem;
        logic       ir_load, reg_wr, mem_rd, mem_wr, pc_wr, st_rd, st_wr;
        logic [1:0] pc_src;
        logic       add1, add2;
        logic       chk_ex;
        logic [3:0] alu;
        logic       alu_src, ex_src, ex_sign;
        logic       chk_wb, wb_data;
        logic [3:0] sp;
        logic       err;
    } rec_t;

    rec_t plan_q[$];
    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_sp  = 0;
    bit   m_err = 1'b0;

    function automatic rec_t blank(input logic [2:0] s);
        rec_t r;
        r = '{default: '0};
        r.st     = s;
        r.pc_src = 2'd2;
        r.sp     = m_sp[3:0];
        r.err    = m_err;
        return r;
    endfunction

    function automatic logic [3:0] alu_of(input logic [1:0] t, input int f);
        case (t)
            2'b00:   return (f == 0) ? 4'd2 : (f == 1) ? 4'd0 : 4'd1;
            2'b10:   return (f == 0) ? 4'd2 : (f == 4) ? 4'd1 : 4'd0;
            2'b11:   return (f % 2 == 0) ? 4'd5 : 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    task automatic add_err();
        m_err = 1'b1;
        repeat (2) plan_q.push_back(blank(3'd7));
    endtask

    task automatic do_stack(input bit push);
        rec_t r;
        r = blank(3'd5);
        if ((push && m_sp == 8) || (!push && m_sp == 0)) begin
            plan_q.push_back(r);
            add_err();
        end else begin
            r.pc_wr = 1'b1;
            if (push) begin
                r.st_wr = 1'b1; r.pc_src = 2'd1; m_sp++;
            end else begin
                r.st_rd = 1'b1; r.pc_src = 2'd0; m_sp--;
            end
            plan_q.push_back(r);
        end
    endtask

    task automatic finish_instr(input rec_t r, input bit stop);
        if (!stop) r.pc_wr = 1'b1;
        plan_q.push_back(r);
        if (stop) do_stack(1'b0);
    endtask

    // Plans the whole cycle trace of one instruction from its IF entry.
    task automatic build(input logic [1:0] t, input int f, input bit stop, input bit z,
                         input int iw, input int dw);
        rec_t r;
        int   lim;
        bit   lw, sw;
        plan_q.delete();
        for (int k = 0; k < iw; k++) plan_q.push_back(blank(3'd0));
        r = blank(3'd0); r.imem = 1'b1; r.ir_load = 1'b1; plan_q.push_back(r);
        lim = (t == 2'b00) ? 3 : (t == 2'b10) ? 4 : (t == 2'b01) ? 2 : 3;
        r = blank(3'd1);
        if (f > lim) begin
            plan_q.push_back(r); add_err(); return;
        end
        if (t == 2'b01) begin
            if (f == 0) begin
                r.pc_wr = 1'b1; r.pc_src = 2'd1; plan_q.push_back(r); return;
            end
            plan_q.push_back(r); do_stack(f == 1); return;
        end
        plan_q.push_back(r);
        r = blank(3'd2);
        r.chk_ex = 1'b1; r.alu = alu_of(t, f);
        r.alu_src = (t == 2'b10) || (t == 2'b11 && f < 2);
        r.ex_src = (t == 2'b10); r.ex_sign = (t == 2'b10);
        lw = (t == 2'b10 && f == 2);
        sw = (t == 2'b10 && f == 3);
        if ((t == 2'b00 && f == 3) || (t == 2'b10 && f == 4)) begin
            if (t == 2'b10 && z) begin
                r.pc_src = 2'd1; r.add1 = 1'b1; r.add2 = 1'b1;
            end
            finish_instr(r, stop); return;
        end
        plan_q.push_back(r);
        if (lw || sw) begin
            for (int k = 0; k < dw; k++) begin
                r = blank(3'd3); r.mem_rd = lw; r.mem_wr = sw; plan_q.push_back(r);
            end
            r = blank(3'd3); r.dmem = 1'b1; r.mem_rd = lw; r.mem_wr = sw;
            if (sw) begin
                finish_instr(r, stop); return;
            end
            plan_q.push_back(r);
        end
        r = blank(3'd4); r.reg_wr = 1'b1; r.chk_wb = 1'b1; r.wb_data = lw;
        finish_instr(r, stop);
    endtask

    task automatic drive(input logic [1:0] t, input int f, input bit stop, input bit z,
                         input int max_n);
        int n = 0;
        while (plan_q.size() > 0 && n < max_n) begin
            rec_t r;
            r = plan_q.pop_front();
            @(posedge clk); #1;
            inst_type = t; inst_function = f[4:0]; stop_bit = stop; zero_flag = z;
            imem_ready = r.imem; dmem_ready = r.dmem;
            exp_q.push_back(r);
            n++;
        end
        plan_q.delete();
        $display("instr type=%0d func=%0d stop=%0d zero=%0d cycles=%0d model_sp=%0d model_err=%0d",
                 t, f, stop, z, n, m_sp, m_err);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic run(input logic [1:0] t, input int f, input bit stop, input bit z,
                       input int iw, input int dw);
        build(t, f, stop, z, iw, dw);
        drive(t, f, stop, z, 1000);
        drain();
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        m_sp = 0; m_err = 1'b0;
        $display("reset released");
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            rec_t e;
            bit   ok;
            e  = exp_q.pop_front();
            ok = (state === e.st) && (ir_load === e.ir_load) && (reg_wr === e.reg_wr) &&
                 (mem_rd === e.mem_rd) && (mem_wr === e.mem_wr) && (pc_wr === e.pc_wr) &&
                 (pc_src === e.pc_src) && (st_rd === e.st_rd) && (st_wr === e.st_wr) &&
                 (sp_count === e.sp) && (err === e.err);
            if (e.chk_ex)
                ok = ok && (alu_op === e.alu) && (alu_src === e.alu_src) &&
                     (ex_src === e.ex_src) && (ex_sign === e.ex_sign);
            if (e.chk_wb) ok = ok && (wb_data === e.wb_data);
            if (e.pc_wr && e.pc_src == 2'd1)
                ok = ok && (pc_add_src1 === e.add1) && (pc_add_src2 === e.add2);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL cycle t=%0t got st=%0d ir=%b rw=%b mr=%b mw=%b pw=%b ps=%0d a=%b%b sr=%b sw=%b sp=%0d err=%b alu=%0d as=%b es=%b%b wb=%b | want st=%0d ir=%b rw=%b mr=%b mw=%b pw=%b ps=%0d a=%b%b sr=%b sw=%b sp=%0d err=%b alu=%0d as=%b es=%b%b wb=%b",
                         $time, state, ir_load, reg_wr, mem_rd, mem_wr, pc_wr, pc_src,
                         pc_add_src1, pc_add_src2, st_rd, st_wr, sp_count, err, alu_op,
                         alu_src, ex_src, ex_sign, wb_data,
                         e.st, e.ir_load, e.reg_wr, e.mem_rd, e.mem_wr, e.pc_wr, e.pc_src,
                         e.add1, e.add2, e.st_rd, e.st_wr, e.sp, e.err, e.alu,
                         e.alu_src, e.ex_src, e.ex_sign, e.wb_data);
            end
        end
    end

    initial begin
        int mem_cnt;
        do_reset();
        #1;
        chk("rst_state", state, 0);
        chk("rst_sp", sp_count, 0);
        chk("rst_err", err, 0);
        chk("rst_pc_src", pc_src, 2);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_strobes", {ir_load, reg_wr, mem_rd, mem_wr, pc_wr, st_rd, st_wr}, 0);

        build(2'b00, 1, 1'b0, 1'b0, 0, 0);
        chk("add_plan_len", plan_q.size(), 4);
        chk("add_plan_wb_regwr", plan_q[3].reg_wr, 1);
        drive(2'b00, 1, 1'b0, 1'b0, 1000); drain();
        run(2'b00, 1, 1'b0, 1'b0, 2, 0);

        build(2'b10, 2, 1'b0, 1'b0, 0, 3);
        chk("lw_plan_len", plan_q.size(), 8);
        mem_cnt = 0;
        foreach (plan_q[k]) if (plan_q[k].mem_rd) mem_cnt++;
        chk("lw_plan_mem_cycles", mem_cnt, 4);
        drive(2'b10, 2, 1'b0, 1'b0, 1000); drain();

        run(2'b10, 3, 1'b0, 1'b0, 0, 1);
        run(2'b10, 4, 1'b0, 1'b1, 0, 0);
        run(2'b10, 4, 1'b0, 1'b0, 1, 0);
        run(2'b11, 0, 1'b0, 1'b0, 0, 0);
        run(2'b11, 3, 1'b0, 1'b0, 0, 0);
        run(2'b10, 0, 1'b0, 1'b0, 0, 0);
        run(2'b00, 3, 1'b0, 1'b1, 0, 0);
        run(2'b01, 0, 1'b0, 1'b0, 0, 0);

        run(2'b00, 2, 1'b1, 1'b0, 0, 0);
        chk("underflow_err", err, 1);
        chk("underflow_state", state, 7);
        do_reset();

        run(2'b01, 1, 1'b0, 1'b0, 0, 0);
        run(2'b01, 1, 1'b0, 1'b0, 0, 0);
        chk("two_jal_sp", sp_count, 2);
        run(2'b00, 2, 1'b1, 1'b0, 0, 0);
        chk("stop_pop_sp", sp_count, 1);
        run(2'b01, 2, 1'b0, 1'b0, 0, 0);
        chk("ret_sp", sp_count, 0);
        do_reset();

        for (int k = 0; k < 8; k++) run(2'b01, 1, 1'b0, 1'b0, 0, 0);
        chk("jal_full_sp", sp_count, 8);
        run(2'b01, 1, 1'b0, 1'b0, 0, 0);
        chk("overflow_err", err, 1);
        chk("overflow_state", state, 7);
        chk("overflow_sp", sp_count, 8);
        do_reset();

        run(2'b00, 5, 1'b0, 1'b0, 0, 0);
        chk("illegal_err", err, 1);
        do_reset();
        #1;
        chk("post_rst_state", state, 0);
        chk("post_rst_sp", sp_count, 0);
        chk("post_rst_err", err, 0);

        build(2'b10, 2, 1'b0, 1'b0, 0, 10);
        drive(2'b10, 2, 1'b0, 1'b0, 5);
        @(negedge clk); #1;
        chk("mid_mem_state", state, 3);
        chk("mid_mem_rd", mem_rd, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_mem_rd", mem_rd, 0);
        @(posedge clk); #2 rst = 1'b0;
        m_sp = 0; m_err = 1'b0;
        run(2'b00, 1, 1'b0, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
